img_wr_stage: RTL and testbench

//  Upstream write stage for frame_buf/ram_int_4p port 0: accepts a non-stallable camera pixel

---
 rtl/img_wr_stage_pkg.sv | 29 ++
 rtl/img_wr_stage_fifo.sv | 64 ++++++
 rtl/img_wr_stage.sv | 150 +++++++++++++++
 tb/tb_img_wr_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_wr_stage_pkg.sv
// Shared widths, FSM state encoding and frame-buffer base selection for the image write stage.
package img_wr_stage_pkg;

  localparam int PIX_W  = 24;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_t;

  function automatic logic [ADDR_W-1:0] frame_base(
    input logic              sel,
    input logic [ADDR_W-1:0] base0,
    input logic [ADDR_W-1:0] base1
  );
    logic [ADDR_W-1:0] base_s;
    if (sel) begin
      base_s = base1;
    end else begin
      base_s = base0;
    end
    return base_s;
  endfunction

endpackage

// File: rtl/img_wr_stage_fifo.sv
// Single-clock first-word-fall-through FIFO; a push on a full FIFO is accepted when a pop frees the slot.
module img_wr_stage_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             single
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == CNT_FULL);
  assign single    = (count_r == CNT_ONE);
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array, left unreset so it can map onto a register file.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; reset discards all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/img_wr_stage.sv
// Camera pixel write stage: buffers a non-stallable pixel stream and writes it word by word
// into one of two ping-pong frame buffers, flagging dropped pixels and misplaced sof strobes.
module img_wr_stage
  import img_wr_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FRAME_PIXELS = 24'd307200,
  parameter logic [ADDR_W-1:0] FRAME_BASE0  = 24'h000000,
  parameter logic [ADDR_W-1:0] FRAME_BASE1  = 24'h080000,
  parameter int                FIFO_DEPTH   = 16
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              wr_rdy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              buf_sel,
  output logic              frame_done,
  output logic              overflow,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] CNT_ONE = 24'd1;

  wr_state_t         state_r, state_s;
  logic [ADDR_W-1:0] pix_cnt_r, pix_cnt_s;
  logic [ADDR_W-1:0] wr_cnt_r, wr_cnt_s;
  logic [ADDR_W-1:0] drop_cnt_r, drop_cnt_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic              buf_sel_r, buf_sel_s;
  logic              frame_done_r, overflow_r, frame_err_r;
  logic [PIX_W-1:0]  head_s;
  logic              empty_s, full_s, single_s;
  logic              pop_s, start_s, take_s, drop_s, push_s, sof_err_s, drained_s;

  img_wr_stage_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wr_clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (pix_data),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s),
    .full      (full_s),
    .single    (single_s)
  );

  // Per-cycle pixel and write strobes; a pop on a full FIFO makes room for this cycle's pixel.
  always_comb begin
    pop_s     = !empty_s && wr_rdy;
    start_s   = (state_r == ST_IDLE) && sof && capture_en;
    take_s    = pix_valid && (start_s || (state_r == ST_CAPTURE));
    drop_s    = take_s && full_s && !pop_s;
    push_s    = take_s && !drop_s;
    sof_err_s = sof && (state_r != ST_IDLE);
    drained_s = empty_s || (single_s && pop_s);
  end

  // Next-state and counter logic; draining looks one write ahead so frame_done follows the last write.
  always_comb begin
    state_s    = state_r;
    pix_cnt_s  = pix_cnt_r;
    wr_cnt_s   = pop_s ? (wr_cnt_r + CNT_ONE) : wr_cnt_r;
    drop_cnt_s = drop_s ? (drop_cnt_r + CNT_ONE) : drop_cnt_r;
    buf_sel_s  = buf_sel_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s   = ST_CAPTURE;
          buf_sel_s = !buf_sel_r;
          pix_cnt_s = take_s ? CNT_ONE : '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (take_s) begin
          pix_cnt_s = pix_cnt_r + CNT_ONE;
          if (pix_cnt_s == FRAME_PIXELS) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (drained_s && (wr_cnt_s == (pix_cnt_r - drop_cnt_r))) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        pix_cnt_s  = '0;
        wr_cnt_s   = '0;
        drop_cnt_s = '0;
      end
      default: begin
        state_s    = ST_IDLE;
        pix_cnt_s  = '0;
        wr_cnt_s   = '0;
        drop_cnt_s = '0;
      end
    endcase
  end

  // State, counters, address and sticky flags.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pix_cnt_r    <= '0;
      wr_cnt_r     <= '0;
      drop_cnt_r   <= '0;
      buf_sel_r    <= 1'b0;
      wr_addr_r    <= FRAME_BASE0;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      pix_cnt_r    <= pix_cnt_s;
      wr_cnt_r     <= wr_cnt_s;
      drop_cnt_r   <= drop_cnt_s;
      buf_sel_r    <= buf_sel_s;
      wr_addr_r    <= frame_base(buf_sel_s, FRAME_BASE0, FRAME_BASE1) + wr_cnt_s;
      frame_done_r <= (state_s == ST_DONE);
      overflow_r   <= overflow_r || drop_s;
      frame_err_r  <= frame_err_r || sof_err_s;
    end
  end

  assign wr_en      = pop_s;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = empty_s ? '0 : {8'h00, head_s};
  assign buf_sel    = buf_sel_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_img_wr_stage.sv
// Directed bench for img_wr_stage with a queue-level model checked every cycle plus literal pins.
module tb_img_wr_stage;

  localparam logic [23:0] FP    = 24'd8;
  localparam int          FPI   = 8;
  localparam logic [23:0] B0    = 24'h000000;
  localparam logic [23:0] B1    = 24'h000100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, capture_en, sof, pix_valid, wr_rdy;
  logic [23:0] pix_data;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic        buf_sel, frame_done, overflow, frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int bad_en = 0;
  logic [23:0] log_addr[$];
  logic [31:0] log_data[$];

  logic [23:0] m_q[$];
  bit m_active = 1'b0, m_done = 1'b0, m_buf = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;
  int m_pix = 0, m_writes = 0;
  bit exp_en;

  img_wr_stage #(
    .FRAME_PIXELS (FP),
    .FRAME_BASE0  (B0),
    .FRAME_BASE1  (B1),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .wr_clk     (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .wr_rdy     (wr_rdy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .buf_sel    (buf_sel),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is counted pixel by pixel, pixels queue up to DEPTH, one write per ready cycle.
  task automatic model_step();
    bit pop, was_done, finish;
    if (reset) begin
      m_q.delete();
      m_active = 1'b0; m_done = 1'b0; m_buf = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
      m_pix = 0; m_writes = 0;
      return;
    end
    was_done = m_done;
    pop = (m_q.size() > 0) && wr_rdy;
    finish = m_active && (m_pix == FPI) && (m_q.size() == (pop ? 1 : 0));
    if (sof && (m_active || was_done)) m_ferr = 1'b1;
    if (!m_active && !was_done && sof && capture_en) begin
      m_active = 1'b1; m_buf = !m_buf; m_pix = 0; m_writes = 0;
    end
    if (pop) begin
      void'(m_q.pop_front());
      m_writes++;
    end
    if (pix_valid && m_active && (m_pix < FPI)) begin
      m_pix++;
      if (m_q.size() < DEPTH) m_q.push_back(pix_data);
      else m_ovf = 1'b1;
    end
    m_done = finish;
    if (finish) m_active = 1'b0;
  endtask

  // Every-cycle compare on the falling edge, then advance the model with the inputs the next edge sees.
  always @(negedge clk) begin
    exp_en = (m_q.size() > 0) && wr_rdy;
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    if (exp_en) begin
      chk("wr_addr", 32'(wr_addr), 32'((m_buf ? B1 : B0) + 24'(m_writes)));
      chk("wr_data", wr_data, {8'h00, m_q[0]});
    end
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("buf_sel", 32'(buf_sel), 32'(m_buf));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      last_wr_cyc = cyc;
      if (!wr_rdy) bad_en++;
    end
    if (frame_done) begin
      done_seen++;
      done_cyc = cyc;
    end
    model_step();
  end

  function automatic logic [31:0] la(input int i);
    return (log_addr.size() > i) ? 32'(log_addr[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ld(input int i);
    return (log_data.size() > i) ? log_data[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic drive(input logic s, input logic pv, input logic [23:0] d, input logic rdy);
    sof = s; pix_valid = pv; pix_data = d; wr_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic rdy);
    drive(1'b1, 1'b1, 24'd1, rdy);
    for (int k = 2; k <= 8; k++) drive(1'b0, 1'b1, 24'(k), rdy);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_seen == d0 && n < 100) begin
      drive(1'b0, 1'b0, 24'd0, 1'b1);
      n++;
    end
    chk("frame_done_seen", 32'(done_seen - d0), 32'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    int d0;
    reset = 1'b1; capture_en = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_data = 24'd0; wr_rdy = 1'b1;
    drive(1'b0, 1'b0, 24'd0, 1'b1);
    drive(1'b0, 1'b0, 24'd0, 1'b1);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_buf_sel", 32'(buf_sel), 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 24'd0, 1'b1);

    // Frame 1: back-to-back, always ready, lands in buffer 1.
    clear_log(); d0 = done_seen;
    frame(1'b1);
    wait_done(d0);
    chk("t1_count", 32'(log_addr.size()), 32'd8);
    chk("t1_first_addr", la(0), 32'h100);
    chk("t1_first_data", ld(0), 32'h1);
    chk("t1_last_addr", la(7), 32'h107);
    chk("t1_last_data", ld(7), 32'h8);
    chk("t1_done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("t1_buf_sel", 32'(buf_sel), 32'h1);
    chk("t1_flags", {30'd0, overflow, frame_err}, 32'h0);

    // Frames 2 and 3 ping-pong between the buffers.
    clear_log(); d0 = done_seen;
    frame(1'b1);
    wait_done(d0);
    chk("t2_first_addr", la(0), 32'h000);
    chk("t2_last_addr", la(7), 32'h007);
    chk("t2_buf_sel", 32'(buf_sel), 32'h0);
    clear_log(); d0 = done_seen;
    frame(1'b1);
    wait_done(d0);
    chk("t2b_first_addr", la(0), 32'h100);

    // Ready toggling, pixels every other cycle, buffer 0.
    clear_log(); d0 = done_seen; bad_en = 0;
    for (int i = 0; i < 16; i++)
      drive(i == 0, (i % 2) == 0, 24'(i / 2 + 1), (i % 2) == 1);
    wait_done(d0);
    chk("t4_count", 32'(log_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("t4_order", ld(i), 32'(i + 1));
    chk("t4_en_without_rdy", 32'(bad_en), 32'd0);
    chk("t4_overflow", 32'(overflow), 32'h0);

    // Stray sof mid-frame, and two extra pixels past the frame end, buffer 1.
    clear_log(); d0 = done_seen;
    for (int i = 0; i < 10; i++) drive(i == 0 || i == 2, 1'b1, 24'(i + 1), 1'b1);
    wait_done(d0);
    chk("t5_count", 32'(log_data.size()), 32'd8);
    chk("t5_last_data", ld(7), 32'h8);
    chk("t5_frame_err", 32'(frame_err), 32'h1);
    clear_log();
    capture_en = 1'b0;
    drive(1'b1, 1'b1, 24'h55, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 24'h56, 1'b1);
    chk("t5_disarmed_writes", 32'(log_data.size()), 32'd0);
    chk("t5_disarmed_buf", 32'(buf_sel), 32'h1);
    capture_en = 1'b1;

    // Ready held low through the frame: four buffered, four dropped, buffer 0.
    clear_log(); d0 = done_seen;
    frame(1'b0);
    wait_done(d0);
    chk("t3_count", 32'(log_data.size()), 32'd4);
    chk("t3_last_addr", la(3), 32'h003);
    chk("t3_last_data", ld(3), 32'h4);
    chk("t3_overflow", 32'(overflow), 32'h1);

    // Reset mid-frame after pixel 5, then a fresh frame starts again at buffer 1.
    d0 = done_seen;
    drive(1'b1, 1'b1, 24'd1, 1'b1);
    for (int k = 2; k <= 5; k++) drive(1'b0, 1'b1, 24'(k), 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 24'd0, 1'b1);
    chk("t6_wr_en", 32'(wr_en), 32'h0);
    chk("t6_wr_addr", 32'(wr_addr), 32'h0);
    chk("t6_wr_data", wr_data, 32'h0);
    chk("t6_flags", {28'd0, buf_sel, frame_done, overflow, frame_err}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 24'd0, 1'b1);
    chk("t6_no_done", 32'(done_seen - d0), 32'd0);
    clear_log(); d0 = done_seen;
    frame(1'b1);
    wait_done(d0);
    chk("t6_count", 32'(log_addr.size()), 32'd8);
    chk("t6_first_addr", la(0), 32'h100);
    chk("t6_first_data", ld(0), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
